// File: rtl/seq_mult_4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/busy/done handshake.
// One ripple-carry add per iteration; the 8-bit product is ready four cycles after start is accepted.
module seq_mult_4x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] acc;
    logic [3:0] m;
    logic [3:0] q;
    logic [1:0] cnt;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       cout;
    logic       carry;

    // Ripple-carry adder: acc plus the multiplicand when the current multiplier bit is set
    always_comb begin
        addend = q[0] ? m : 4'h0;
        sum    = 4'h0;
        carry  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = acc[i] ^ addend[i] ^ carry;
            carry  = (acc[i] & addend[i]) | (carry & (acc[i] ^ addend[i]));
        end
        cout = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 8'h00;
            acc     <= 4'h0;
            m       <= 4'h0;
            q       <= 4'h0;
            cnt     <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= 4'h0;
                        m     <= a;
                        q     <= b;
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    // The carry-out becomes the top bit of acc after the 9-bit right shift
                    {acc, q} <= {cout, sum, q[3:1]};
                    cnt      <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= {cout, sum, q[3:1]};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Directed self-checking bench for seq_mult_4x4: handshake timing, arithmetic,
// ignored starts, back-to-back operation, mid-operation reset and a full operand sweep.
module tb_seq_mult_4x4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int tests;
    int fails;

    seq_mult_4x4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until done is seen, or -1 if it never arrives
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [3:0] av, input logic [3:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = 4'h0;
        b = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++;
        if (product !== 8'h00) begin fails++; $display("FAIL reset_product got %h want 00", product); end
    endtask

    task automatic test_basic();
        issue(4'hD, 4'hB);
        for (int i = 1; i <= 3; i++) begin
            tests++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL basic_busy cycle %0d got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            tick();
        end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy4 got %b want 1", busy); end
        tick();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done got done=%b busy=%b want done=1 busy=0", done, busy);
        end
        tests++;
        if (product !== 8'h8F) begin fails++; $display("FAIL basic_product got %h want 8f", product); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (done !== 1'b0 || product !== 8'h8F) begin
                fails++;
                $display("FAIL basic_hold got done=%b product=%h want done=0 product=8f", done, product);
            end
        end
    endtask

    task automatic test_carry_and_zero();
        int lat;
        issue(4'hF, 4'hF);
        wait_done(lat);
        tests++;
        if (lat !== 4 || product !== 8'hE1) begin
            fails++;
            $display("FAIL carry_ff got lat=%0d product=%h want lat=4 product=e1", lat, product);
        end
        tick();
        issue(4'h0, 4'h9);
        wait_done(lat);
        tests++;
        if (lat !== 4 || product !== 8'h00) begin
            fails++;
            $display("FAIL zero_a got lat=%0d product=%h want lat=4 product=00", lat, product);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int ndone;
        issue(4'h3, 4'h5);
        tick();
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_mid got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        tick();
        tests++;
        if (done !== 1'b1 || product !== 8'h0F) begin
            fails++;
            $display("FAIL busy_ignore_result got done=%b product=%h want done=1 product=0f", done, product);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin fails++; $display("FAIL busy_ignore_extra got %0d extra cycles want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(4'h3, 4'h5);
        wait_done(lat);
        a = 4'h2;
        b = 4'h7;
        start = 1'b1;
        tests++;
        if (lat !== 4 || product !== 8'h0F) begin
            fails++;
            $display("FAIL b2b_first got lat=%0d product=%h want lat=4 product=0f", lat, product);
        end
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done(lat);
        tests++;
        if (lat !== 4 || product !== 8'h0E) begin
            fails++;
            $display("FAIL b2b_second got lat=%0d product=%h want lat=4 product=0e", lat, product);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int nevents;
        int lat;
        issue(4'h9, 4'h9);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid got busy=%b done=%b product=%h want 0 0 00", busy, done, product);
        end
        nevents = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) nevents++;
        end
        tests++;
        if (nevents !== 0) begin fails++; $display("FAIL rst_mid_after got %0d active cycles want 0", nevents); end
        a = 4'h9;
        b = 4'h9;
        start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_wins got busy=%b want 0", busy); end
        issue(4'h9, 4'h9);
        wait_done(lat);
        tests++;
        if (lat !== 4 || product !== 8'h51) begin
            fails++;
            $display("FAIL rst_fresh got lat=%0d product=%h want lat=4 product=51", lat, product);
        end
        tick();
    endtask

    task automatic test_sweep();
        int lat;
        logic [7:0] expected;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                expected = 8'(i * j);
                issue(4'(i), 4'(j));
                a = 4'(15 - i);
                b = 4'(15 - j);
                wait_done(lat);
                tests++;
                if (lat !== 4 || product !== expected) begin
                    fails++;
                    $display("FAIL sweep %0d*%0d got lat=%0d product=%h want lat=4 product=%h",
                             i, j, lat, product, expected);
                end
                tick();
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_carry_and_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
